// File: rtl/icache_responder_pkg.sv
// Shared geometry, FSM states and address helpers for the instruction cache.
// The fetch-side responder and its tag/data array both import this package.
package icache_responder_pkg;

  localparam int IC_INDEX_W  = 6;
  localparam int IC_OFFSET_W = 4;
  localparam int IC_WORDS    = 1 << (IC_OFFSET_W - 2);

  localparam logic [31:0] IC_PADDR_MASK = 32'h1FFF_FFFF;

  typedef enum logic [2:0] {
    IC_IDLE,
    IC_MREQ,
    IC_REFILL,
    IC_UREQ,
    IC_UWAIT,
    IC_UDONE
  } ic_state_e;

  function automatic logic [31:0] ic_paddr(
    input logic [31:0] va
  );
    return va & IC_PADDR_MASK;
  endfunction

endpackage

// File: rtl/ic_tag_data_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read by index; refill writes one word per beat.
module ic_tag_data_array
  import icache_responder_pkg::*;
#(
  parameter int INDEX_W = IC_INDEX_W,
  parameter int TAG_W   = 32 - IC_INDEX_W - IC_OFFSET_W,
  parameter int WORD_W  = IC_OFFSET_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [WORD_W-1:0]  rd_word,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [31:0]        wr_data,
  input  logic               wr_last,
  input  logic [TAG_W-1:0]   wr_tag
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  // A line being refilled stays invalid until its last beat lands,
  // so an abandoned refill never leaves a half-written valid line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index][wr_word] <= wr_data;
      if (wr_last) begin
        tag_q[wr_index] <= wr_tag;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/icache_responder.sv
// Fetch-side SRAM responder backed by a direct-mapped I-cache.
// Misses refill a line over the burst bridge; kseg1 reads bypass.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int INDEX_W = IC_INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        stallreq,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_len,
  input  logic        mem_rd_ready,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_last
);

  localparam int OFFSET_W = IC_OFFSET_W;
  localparam int WORDS    = IC_WORDS;
  localparam int WORD_W   = OFFSET_W - 2;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

  ic_state_e         state_q, state_d;
  logic [WORD_W-1:0] cnt_q;
  logic [31:0]       lat_q, ubuf_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       paddr, lat_pa;
  logic              uncached, hit;
  logic              latch, stall;
  logic              fill_we, fill_last;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              unused_ok;

  assign paddr     = ic_paddr(inst_sram_addr);
  assign lat_pa    = ic_paddr(lat_q);
  assign uncached  = inst_sram_addr[31:29] == 3'b101;
  assign hit       = rd_valid
                  && rd_tag == paddr[31 -: TAG_W];
  assign fill_we   = state_q == IC_REFILL
                  && mem_rd_valid;
  assign fill_last = cnt_q == WORD_W'(WORDS - 1);

  ic_tag_data_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .WORD_W  (WORD_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (paddr[OFFSET_W +: INDEX_W]),
    .rd_word  (paddr[2 +: WORD_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_we),
    .wr_index (lat_pa[OFFSET_W +: INDEX_W]),
    .wr_word  (cnt_q),
    .wr_data  (mem_rd_data),
    .wr_last  (fill_last),
    .wr_tag   (lat_pa[31 -: TAG_W])
  );

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
    latch       = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    mem_rd_len  = 1'b0;
    unique case (state_q)
      IC_IDLE: begin
        if (inst_sram_en) begin
          if (uncached) begin
            stall   = 1'b1;
            latch   = 1'b1;
            state_d = IC_UREQ;
          end else if (hit) begin
            rdata_d = rd_data;
          end else begin
            stall   = 1'b1;
            latch   = 1'b1;
            state_d = IC_MREQ;
          end
        end
      end
      IC_MREQ: begin
        stall       = 1'b1;
        mem_rd_req  = 1'b1;
        mem_rd_len  = 1'b1;
        mem_rd_addr = {lat_pa[31:OFFSET_W],
                       OFFSET_W'(0)};
        if (mem_rd_ready) state_d = IC_REFILL;
      end
      IC_REFILL: begin
        stall = 1'b1;
        if (fill_we && fill_last) state_d = IC_IDLE;
      end
      IC_UREQ: begin
        stall       = 1'b1;
        mem_rd_req  = 1'b1;
        mem_rd_addr = {lat_pa[31:2], 2'b00};
        if (mem_rd_ready) state_d = IC_UWAIT;
      end
      IC_UWAIT: begin
        stall = 1'b1;
        if (mem_rd_valid) state_d = IC_UDONE;
      end
      IC_UDONE: begin
        // A redirected fetch drops ubuf and is looked up again in IDLE.
        state_d = IC_IDLE;
        if (inst_sram_en && inst_sram_addr == lat_q) begin
          rdata_d = ubuf_q;
        end else begin
          stall = inst_sram_en;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IC_IDLE;
      rdata_q <= '0;
      lat_q   <= '0;
      ubuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (latch) begin
        lat_q <= inst_sram_addr;
        cnt_q <= '0;
      end else if (fill_we) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == IC_UWAIT && mem_rd_valid) begin
        ubuf_q <= mem_rd_data;
      end
    end
  end

  assign stallreq        = stall && rst;
  assign inst_sram_rdata = rdata_q;

  assign unused_ok = ^{inst_sram_wen, inst_sram_wdata,
                       mem_rd_last, paddr[1:0], lat_pa[1:0]};

endmodule
